dmem_dma: RTL and testbench



---
 rtl/dmem_dma.sv | 147 ++++++++++++++
 tb/tb_dmem_dma.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dma.sv
// dmem_dma: block-copy initiator driving the dmem port while busy.
// Optional block-fill mode is built when DMEM_DMA_FILL_EN is defined.
module dmem_dma #(
  parameter int unsigned N = 16,
  parameter int unsigned R = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [R-1:0] src_addr,
  input  logic [R-1:0] dst_addr,
  input  logic [R-1:0] length,
`ifdef DMEM_DMA_FILL_EN
  input  logic         fill,
  input  logic [N-1:0] fill_value,
`endif
  input  logic [N-1:0] dmem_readdata,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_writedata,
  output logic         dmem_write_enable,
  output logic         busy,
  output logic         done,
  output logic         aborted
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [R-1:0] src_ptr;
  logic [R-1:0] dst_ptr;
  logic [R-1:0] count;
  logic [N-1:0] data_buf;
  logic         fill_go;
  logic         fill_mode;
  logic         active;

`ifdef DMEM_DMA_FILL_EN
  logic fill_q;

  assign fill_go   = fill;
  assign fill_mode = fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= 1'b0;
    end else if (state == IDLE && start) begin
      fill_q <= fill;
    end
  end
`else
  assign fill_go   = 1'b0;
  assign fill_mode = 1'b0;
`endif

  assign active = (state == READ) || (state == WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      count    <= '0;
      data_buf <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= src_addr;
            dst_ptr <= dst_addr;
            count   <= length;
`ifdef DMEM_DMA_FILL_EN
            // Fill reuses the write buffer as the constant source.
            if (fill) data_buf <= fill_value;
`endif
          end
        end
        READ: begin
          if (!abort) data_buf <= dmem_readdata;
        end
        WRITE: begin
          if (!abort) begin
            src_ptr <= src_ptr + 1'b1;
            dst_ptr <= dst_ptr + 1'b1;
            count   <= count - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) state_nxt = DONE;
          else if (fill_go) state_nxt = WRITE;
          else state_nxt = READ;
        end
      end
      READ: begin
        state_nxt = abort ? IDLE : WRITE;
      end
      WRITE: begin
        if (abort) state_nxt = IDLE;
        else if (count == R'(1)) state_nxt = DONE;
        else if (fill_mode) state_nxt = WRITE;
        else state_nxt = READ;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dmem_addr         = '0;
    dmem_writedata    = '0;
    dmem_write_enable = 1'b0;
    unique case (state)
      READ: begin
        dmem_addr = {{(N-R){1'b0}}, src_ptr};
      end
      WRITE: begin
        dmem_addr         = {{(N-R){1'b0}}, dst_ptr};
        dmem_writedata    = data_buf;
        dmem_write_enable = !abort;
      end
      default: ;
    endcase
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign aborted = abort && active;

endmodule

// File: tb/tb_dmem_dma.sv
// tb_dmem_dma: table, hand-written and random checks of dmem_dma
// against a word-level memory model.
module tb_dmem_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  src_addr = '0;
  logic [7:0]  dst_addr = '0;
  logic [7:0]  length = '0;
  logic [15:0] dmem_readdata;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_writedata;
  logic        dmem_write_enable;
  logic        busy;
  logic        done;
  logic        aborted;
`ifdef DMEM_DMA_FILL_EN
  logic        fill = 1'b0;
  logic [15:0] fill_value = '0;
`endif

  logic [15:0] mem [0:255];
  logic [15:0] exp_mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_a = '0;
  logic [15:0] pl_d = '0;

  logic [7:0]  rq[$];
  logic [7:0]  wq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          hi_err = 0;

  dmem_dma #(.N(16), .R(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .abort             (abort),
    .src_addr          (src_addr),
    .dst_addr          (dst_addr),
    .length            (length),
`ifdef DMEM_DMA_FILL_EN
    .fill              (fill),
    .fill_value        (fill_value),
`endif
    .dmem_readdata     (dmem_readdata),
    .dmem_addr         (dmem_addr),
    .dmem_writedata    (dmem_writedata),
    .dmem_write_enable (dmem_write_enable),
    .busy              (busy),
    .done              (done),
    .aborted           (aborted)
  );

  always #5 clk = ~clk;

  assign dmem_readdata = mem[dmem_addr[7:0]];

  always @(posedge clk) begin
    if (dmem_write_enable) mem[dmem_addr[7:0]] <= dmem_writedata;
    else if (pl_en) mem[pl_a] <= pl_d;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run_xfer(input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input int inj,
                          output int nb, output int nd, output int nw);
    rq.delete();
    wq.delete();
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length   = l;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    nd = 0;
    nw = 0;
    while (busy && nb < 2000) begin
      nb++;
      if (done) nd++;
      if (dmem_write_enable) begin
        nw++;
        wq.push_back(dmem_addr[7:0]);
      end else if (!done) begin
        rq.push_back(dmem_addr[7:0]);
      end
      if (dmem_addr[15:8] != 8'h00) hi_err++;
      if (nb == inj) begin
        start    = 1'b1;
        src_addr = ~s;
        dst_addr = ~d;
        length   = l + 8'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // Word-level reference: forward copy (or fill) and access order.
  task automatic do_check(input string nm, input logic [7:0] s,
                          input logic [7:0] d, input logic [7:0] l,
                          input int inj, input bit fm,
                          input logic [15:0] fv);
    int nb, nd, nw, ebusy, errs;
    logic [7:0] a;
    exp_mem = mem;
`ifdef DMEM_DMA_FILL_EN
    fill = fm;
    fill_value = fv;
`endif
    hi_err = 0;
    run_xfer(s, d, l, inj, nb, nd, nw);
    for (int i = 0; i < int'(l); i++) begin
      a = d + 8'(i);
      exp_mem[a] = fm ? fv : exp_mem[8'(s + 8'(i))];
    end
    ebusy = (l == 0) ? 1 : (fm ? int'(l) + 1 : 2 * int'(l) + 1);
    chk({nm, " busy_cycles"}, nb, ebusy);
    chk({nm, " done_pulses"}, nd, 1);
    chk({nm, " writes"}, nw, int'(l));
    chk({nm, " reads"}, rq.size(), fm ? 0 : int'(l));
    errs = 0;
    for (int i = 0; i < wq.size(); i++)
      if (wq[i] != 8'(d + 8'(i))) errs++;
    for (int i = 0; i < rq.size(); i++)
      if (rq[i] != 8'(s + 8'(i))) errs++;
    chk({nm, " addr_order"}, errs, 0);
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== exp_mem[i]) errs++;
    chk({nm, " mem_words_wrong"}, errs, 0);
    chk({nm, " addr_high_bits"}, hi_err, 0);
`ifdef DMEM_DMA_FILL_EN
    fill = 1'b0;
`endif
  endtask

  typedef struct {
    string      nm;
    logic [7:0] s;
    logic [7:0] d;
    logic [7:0] l;
    int         inj;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [7:0] rs, rd, rl;
    bit         fm;
    tbl[0] = '{"zero_len", 8'h05, 8'h06, 8'd0, 0};
    tbl[1] = '{"wrap",     8'hFE, 8'h01, 8'd3, 0};
    tbl[2] = '{"overlap",  8'h20, 8'h21, 8'd4, 0};
    tbl[3] = '{"len1",     8'h33, 8'hC0, 8'd1, 0};
    tbl[4] = '{"busy_start", 8'h50, 8'h70, 8'd3, 2};
    tbl[5] = '{"dst_wrap", 8'h80, 8'hFD, 8'd6, 5};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset outputs",
        {dmem_addr, dmem_writedata, 13'd0, dmem_write_enable,
         busy, done}, 0);
    chk("reset aborted", aborted, 0);

    for (int i = 0; i < 256; i++) poke(8'(i), 16'($urandom));

    poke(8'h00, 16'hFFFF);
    poke(8'h01, 16'h00FF);
    poke(8'h02, 16'h0000);
    do_check("basic", 8'h00, 8'h10, 8'd3, 0, 1'b0, 16'h0);
    chk("basic m10", mem[8'h10], 16'hFFFF);
    chk("basic m11", mem[8'h11], 16'h00FF);
    chk("basic m12", mem[8'h12], 16'h0000);

    for (int i = 0; i < 6; i++)
      do_check(tbl[i].nm, tbl[i].s, tbl[i].d, tbl[i].l,
               tbl[i].inj, 1'b0, 16'h0);

    // Abort in WRITE of word 2 of a 4-word copy.
    for (int i = 0; i < 4; i++) poke(8'(8'h40 + i), 16'h1111 * 16'(i + 1));
    exp_mem = mem;
    exp_mem[8'h40] = mem[8'h30];
    @(negedge clk);
    src_addr = 8'h30;
    dst_addr = 8'h40;
    length   = 8'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort first read addr", dmem_addr, 16'h0030);
    repeat (3) @(negedge clk);
    chk("abort pre we", dmem_write_enable, 1);
    abort = 1'b1;
    #1;
    chk("abort gated we", dmem_write_enable, 0);
    chk("abort pulse", aborted, 1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort idle", {busy, done, aborted}, 0);
    repeat (2) @(negedge clk);
    chk("abort no done", {busy, done}, 0);
    for (int i = 0; i < 4; i++)
      chk("abort mem", mem[8'(8'h40 + i)], exp_mem[8'(8'h40 + i)]);

    // Asynchronous reset in the middle of a WRITE cycle.
    @(negedge clk);
    src_addr = 8'h90;
    dst_addr = 8'hA0;
    length   = 8'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst pre we", dmem_write_enable, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst outputs",
        {dmem_addr, dmem_writedata, 13'd0, dmem_write_enable,
         busy, done}, 0);
    chk("rst aborted", aborted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst no resume", {busy, dmem_write_enable}, 0);

`ifdef DMEM_DMA_FILL_EN
    do_check("fill", 8'h00, 8'h20, 8'd4, 0, 1'b1, 16'hA5A5);
    for (int i = 0; i < 4; i++)
      chk("fill value", mem[8'(8'h20 + i)], 16'hA5A5);
`endif

    for (int k = 0; k < 20; k++) begin
      rs = 8'($urandom);
      rd = (k % 3 == 0) ? rs + 8'($urandom_range(1, 4)) : 8'($urandom);
      rl = 8'($urandom_range(0, 12));
      fm = 1'b0;
`ifdef DMEM_DMA_FILL_EN
      fm = 1'($urandom_range(0, 1));
`endif
      do_check("random", rs, rd, rl, int'($urandom_range(0, 6)), fm,
               16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
